// File: rtl/continuous_monitoring_system_pkg.sv
// Shared constants and types for the continuous monitoring system trace path.
package continuous_monitoring_system_pkg;

  localparam int AXI_DATA_WIDTH         = 1024;
  localparam int PACKETIZER_FIFO_DEPTH  = 16;
  localparam int PACKETIZER_HALT_MARGIN = 4;
  localparam int DROP_COUNT_WIDTH       = 32;
  localparam int TLAST_INTERVAL_WIDTH   = 32;

  // What the packetizer writes into its FIFO on a given cycle.
  typedef enum logic [1:0] {
    WR_NONE   = 2'd0,
    WR_ITEM   = 2'd1,
    WR_MARKER = 2'd2
  } wr_kind_e;

endpackage

// File: rtl/cms_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// Pointers carry an extra wrap bit, so full and empty come from the registered pointers alone.
module cms_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  // Head entry shows zero while empty so the stream data is clean between beats.
  assign pop_data  = empty ? '0 : mem_r[rd_ptr_r[AW-1:0]];

  // Storage write; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Read and write pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/cms_axis_trace_packetizer.sv
// Buffers filtered trace items into AXI-Stream packets with TLAST framing and halt-on-full.
// Optional feature: define CMS_PACKETIZER_DROP_COUNT_EN to implement the dropped-item counter.
module cms_axis_trace_packetizer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DATA_W      = AXI_DATA_WIDTH,
  parameter int DEPTH       = PACKETIZER_FIFO_DEPTH,
  parameter int HALT_MARGIN = PACKETIZER_HALT_MARGIN,
  parameter int INTERVAL_W  = TLAST_INTERVAL_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        item_valid,
  input  logic [DATA_W-1:0]           item_data,
  input  logic                        flush,
  input  logic [INTERVAL_W-1:0]       tlast_interval,
  input  logic                        halt_on_full_en,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        halt_o,
  output logic                        fifo_full,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [INTERVAL_W-1:0] cnt_r;
  logic                  pending_flush_r;
  logic                  halt_r;
  logic                  at_interval_s;
  logic                  flush_req_s;
  logic                  item_last_s;
  wr_kind_e              wr_kind_s;
  logic                  fifo_push_s;
  logic [DATA_W:0]       fifo_wdata_s;
  logic [DATA_W:0]       fifo_rdata_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [CNT_W-1:0]      fifo_count_s;

  // Decide whether this cycle writes a real item, a flush marker, or nothing.
  always_comb begin
    at_interval_s = 1'b0;
    if (tlast_interval != '0) begin
      at_interval_s = (cnt_r >= tlast_interval - INTERVAL_W'(1));
    end else begin
      at_interval_s = 1'b0;
    end
    flush_req_s = pending_flush_r | (flush & (cnt_r != '0));
    item_last_s = at_interval_s | flush | pending_flush_r;
    if (item_valid && !fifo_full_s) begin
      wr_kind_s = WR_ITEM;
    end else if (!item_valid && flush_req_s && !fifo_full_s) begin
      wr_kind_s = WR_MARKER;
    end else begin
      wr_kind_s = WR_NONE;
    end
  end

  // Build the FIFO entry: payload with its own tlast bit in the LSB.
  always_comb begin
    fifo_push_s  = 1'b0;
    fifo_wdata_s = '0;
    case (wr_kind_s)
      WR_ITEM: begin
        fifo_push_s  = 1'b1;
        fifo_wdata_s = {item_data, item_last_s};
      end
      WR_MARKER: begin
        fifo_push_s  = 1'b1;
        fifo_wdata_s = {{DATA_W{1'b0}}, 1'b1};
      end
      default: begin
        fifo_push_s  = 1'b0;
        fifo_wdata_s = '0;
      end
    endcase
  end

  // Packet item counter, deferred-flush flag and registered halt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r           <= '0;
      pending_flush_r <= 1'b0;
      halt_r          <= 1'b0;
    end else begin
      case (wr_kind_s)
        WR_ITEM: begin
          cnt_r           <= item_last_s ? '0 : cnt_r + INTERVAL_W'(1);
          pending_flush_r <= 1'b0;
        end
        WR_MARKER: begin
          cnt_r           <= '0;
          pending_flush_r <= 1'b0;
        end
        default: begin
          // A flush that finds the FIFO full waits for the first free slot.
          if (flush_req_s && fifo_full_s) begin
            pending_flush_r <= 1'b1;
          end
        end
      endcase
      halt_r <= halt_on_full_en && (fifo_count_s >= CNT_W'(DEPTH - HALT_MARGIN));
    end
  end

`ifdef CMS_PACKETIZER_DROP_COUNT_EN
  logic [DROP_COUNT_WIDTH-1:0] drop_count_r;

  // Saturating count of items lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_r <= '0;
    end else if (item_valid && fifo_full_s && (drop_count_r != '1)) begin
      drop_count_r <= drop_count_r + DROP_COUNT_WIDTH'(1);
    end
  end

  assign drop_count = drop_count_r;
`else
  assign drop_count = '0;
`endif

  cms_sync_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (fifo_wdata_s),
    .pop       (m_axis_tready),
    .pop_data  (fifo_rdata_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_count_s)
  );

  assign m_axis_tvalid = ~fifo_empty_s;
  assign m_axis_tdata  = fifo_rdata_s[DATA_W:1];
  assign m_axis_tlast  = fifo_rdata_s[0];
  assign fifo_full     = fifo_full_s;
  assign halt_o        = halt_r;

endmodule

// File: tb/tb_cms_axis_trace_packetizer.sv
// Self-checking bench for cms_axis_trace_packetizer: vector table, directed corner cases, random vs. queue model.
module tb_cms_axis_trace_packetizer;

  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;
  localparam int IW     = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          item_valid;
  logic [DW-1:0] item_data;
  logic          flush;
  logic [IW-1:0] tlast_interval;
  logic          halt_on_full_en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          halt_o;
  logic          fifo_full;
  logic [31:0]   drop_count;

  int checks   = 0;
  int failures = 0;

  cms_axis_trace_packetizer #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .HALT_MARGIN (MARGIN),
    .INTERVAL_W  (IW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .item_valid      (item_valid),
    .item_data       (item_data),
    .flush           (flush),
    .tlast_interval  (tlast_interval),
    .halt_on_full_en (halt_on_full_en),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .halt_o          (halt_o),
    .fifo_full       (fifo_full),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] interval;
    logic          iv;
    logic [DW-1:0] data;
    logic          fl;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          el;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    item_valid    = 1'b0;
    item_data     = '0;
    flush         = 1'b0;
    m_axis_tready = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] exp_drop(input int n);
`ifdef CMS_PACKETIZER_DROP_COUNT_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW:0]   q[$];
    logic [31:0]   mcnt;
    logic          mpend;
    logic          mhalt;
    logic [31:0]   mdrop;
    int            ivals[6];
    int            occ;
    logic          mfull;
    logic          boundary;
    logic          last;
    logic          halt_next;

    rst             = 1'b1;
    tlast_interval  = 32'd4;
    halt_on_full_en = 1'b0;

    // interval=4 back-to-back, then interval=0 with flush markers
    vecs[0]  = '{32'd4, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0};
    vecs[1]  = '{32'd4, 1'b1, 32'h101, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0};
    vecs[2]  = '{32'd4, 1'b1, 32'h102, 1'b0, 1'b1, 1'b1, 32'h101, 1'b0};
    vecs[3]  = '{32'd4, 1'b1, 32'h103, 1'b0, 1'b1, 1'b1, 32'h102, 1'b0};
    vecs[4]  = '{32'd4, 1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h103, 1'b1};
    vecs[5]  = '{32'd4, 1'b1, 32'h105, 1'b0, 1'b1, 1'b1, 32'h104, 1'b0};
    vecs[6]  = '{32'd4, 1'b1, 32'h106, 1'b0, 1'b1, 1'b1, 32'h105, 1'b0};
    vecs[7]  = '{32'd4, 1'b1, 32'h107, 1'b0, 1'b1, 1'b1, 32'h106, 1'b0};
    vecs[8]  = '{32'd4, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h107, 1'b1};
    vecs[9]  = '{32'd4, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0};
    vecs[10] = '{32'd0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0};
    vecs[11] = '{32'd0, 1'b1, 32'h201, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0};
    vecs[12] = '{32'd0, 1'b1, 32'h202, 1'b0, 1'b1, 1'b1, 32'h201, 1'b0};
    vecs[13] = '{32'd0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h202, 1'b0};
    vecs[14] = '{32'd0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0,   1'b1};
    vecs[15] = '{32'd0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b0};
    vecs[16] = '{32'd0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0};
    vecs[17] = '{32'd0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0};

    do_reset();
    check("reset_tvalid", m_axis_tvalid, 1'b0);
    check("reset_tlast",  m_axis_tlast,  1'b0);
    check("reset_tdata",  m_axis_tdata,  32'h0);
    check("reset_halt",   halt_o,        1'b0);
    check("reset_full",   fifo_full,     1'b0);
    check("reset_drop",   drop_count,    32'h0);

    for (int i = 0; i < 18; i++) begin
      tlast_interval = vecs[i].interval;
      item_valid     = vecs[i].iv;
      item_data      = vecs[i].data;
      flush          = vecs[i].fl;
      m_axis_tready  = vecs[i].rdy;
      check($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].ed);
        check($sformatf("vec%0d_tlast", i), m_axis_tlast, vecs[i].el);
      end
      tick();
    end

    // halt rises after 12 stored items and falls after draining to 11
    do_reset();
    tlast_interval  = 32'd0;
    halt_on_full_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      item_valid = 1'b1;
      item_data  = 32'h10 + 32'(i);
      tick();
    end
    item_valid = 1'b0;
    check("halt_before_rise", halt_o, 1'b0);
    tick();
    check("halt_rise", halt_o, 1'b1);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    check("halt_hold", halt_o, 1'b1);
    tick();
    check("halt_fall", halt_o, 1'b0);

    // overflow: 20 items into 16 entries, then ordered drain
    do_reset();
    halt_on_full_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      item_valid = 1'b1;
      item_data  = 32'h300 + 32'(i);
      tick();
    end
    item_valid = 1'b0;
    check("ovf_full", fifo_full, 1'b1);
    check("ovf_drop", drop_count, exp_drop(4));
    check("ovf_halt_disabled", halt_o, 1'b0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_beat%0d_valid", i), m_axis_tvalid, 1'b1);
      check($sformatf("ovf_beat%0d_data", i), m_axis_tdata, 32'h300 + 32'(i));
      tick();
    end
    check("ovf_empty_after", m_axis_tvalid, 1'b0);
    check("ovf_not_full_after", fifo_full, 1'b0);

    // flush while full is deferred and appears as a marker after the stored items
    do_reset();
    for (int i = 0; i < 16; i++) begin
      item_valid = 1'b1;
      item_data  = 32'h400 + 32'(i);
      tick();
    end
    item_valid = 1'b0;
    flush      = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("pend_full", fifo_full, 1'b1);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("pend_beat%0d_data", i), m_axis_tdata, 32'h400 + 32'(i));
      check($sformatf("pend_beat%0d_last", i), m_axis_tlast, 1'b0);
      tick();
    end
    check("pend_marker_valid", m_axis_tvalid, 1'b1);
    check("pend_marker_data",  m_axis_tdata,  32'h0);
    check("pend_marker_last",  m_axis_tlast,  1'b1);
    tick();
    check("pend_after_marker", m_axis_tvalid, 1'b0);
    item_valid = 1'b1;
    item_data  = 32'h4AA;
    flush      = 1'b1;
    tick();
    item_valid = 1'b0;
    flush      = 1'b0;
    check("coflush_data", m_axis_tdata, 32'h4AA);
    check("coflush_last", m_axis_tlast, 1'b1);
    tick();
    check("coflush_single_beat", m_axis_tvalid, 1'b0);

    // reset mid-packet discards the queue and restarts the item count
    do_reset();
    tlast_interval  = 32'd0;
    halt_on_full_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      item_valid = 1'b1;
      item_data  = 32'h50 + 32'(i);
      tick();
    end
    item_valid = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_halt",   halt_o,        1'b0);
    tlast_interval = 32'd2;
    item_valid     = 1'b1;
    item_data      = 32'h500;
    tick();
    item_data = 32'h501;
    tick();
    item_valid    = 1'b0;
    m_axis_tready = 1'b1;
    check("rst_fresh0_data", m_axis_tdata, 32'h500);
    check("rst_fresh0_last", m_axis_tlast, 1'b0);
    tick();
    check("rst_fresh1_data", m_axis_tdata, 32'h501);
    check("rst_fresh1_last", m_axis_tlast, 1'b1);
    tick();

    // randomized traffic against a queue model of the packetizing rules
    ivals = '{0, 1, 2, 3, 5, 8};
    do_reset();
    q.delete();
    mcnt  = 32'd0;
    mpend = 1'b0;
    mhalt = 1'b0;
    mdrop = 32'd0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0) begin
        tlast_interval  = 32'(ivals[$urandom_range(0, 5)]);
        halt_on_full_en = 1'($urandom_range(0, 1));
      end
      item_valid    = ($urandom_range(0, 9) < 6);
      item_data     = $urandom;
      flush         = ($urandom_range(0, 19) == 0);
      m_axis_tready = ($urandom_range(0, 9) < (((cyc / 500) % 2 == 1) ? 3 : 8));

      check("rnd_tvalid", m_axis_tvalid, q.size() > 0);
      if (q.size() > 0) begin
        check("rnd_tdata", m_axis_tdata, q[0][DW:1]);
        check("rnd_tlast", m_axis_tlast, q[0][0]);
      end
      check("rnd_full", fifo_full, q.size() == DEPTH);
      check("rnd_halt", halt_o, mhalt);
      check("rnd_drop", drop_count, mdrop);

      occ       = q.size();
      mfull     = (occ == DEPTH);
      halt_next = halt_on_full_en && (occ >= DEPTH - MARGIN);
      boundary  = (tlast_interval != 0) && (mcnt >= tlast_interval - 32'd1);
      if (m_axis_tready && occ > 0) begin
        void'(q.pop_front());
      end
      if (item_valid) begin
        if (!mfull) begin
          last = boundary || flush || mpend;
          q.push_back({item_data, last});
          mcnt  = last ? 32'd0 : mcnt + 32'd1;
          mpend = 1'b0;
        end else begin
`ifdef CMS_PACKETIZER_DROP_COUNT_EN
          if (mdrop != 32'hFFFF_FFFF) mdrop = mdrop + 32'd1;
`endif
          if (flush && mcnt != 0) mpend = 1'b1;
        end
      end else if ((flush && mcnt != 0) || mpend) begin
        if (!mfull) begin
          q.push_back({{DW{1'b0}}, 1'b1});
          mcnt  = 32'd0;
          mpend = 1'b0;
        end else begin
          mpend = 1'b1;
        end
      end
      mhalt = halt_next;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
